alu_op_sequencer: RTL and testbench

Sequential front-end that issues operations to the team's combinational 32-bit ALU (operands Ai/Bi, opcode Op2..Op0, result Ri, flags Cout/Vout/Z) and returns captured results. It accepts tagged requests over a valid/ready interface and drives registered operands and opcode onto the ALU. After a configurable settle window it samples the result and flags into a 2-entry response buffer, drained over a second valid/ready interface.

---
 rtl/alu_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Sequential front-end for the combinational 32-bit ALU. A tagged request is
// accepted over req_valid/req_ready, its operands and opcode are registered
// onto alu_a/alu_b/alu_op, and after SETTLE_CYCLES the ALU result and flags
// are captured into a 2-entry response FIFO drained over rsp_valid/rsp_ready.
//
// Parameters
//   SETTLE_CYCLES  cycles from driving the ALU to sampling it (1..15)
//   TAG_W          request/response tag width
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_a, req_b, req_op, req_tag  request payload
//   alu_a, alu_b, alu_op        registered ALU inputs
//   alu_r, alu_cout, alu_vout, alu_z  ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_r, rsp_cout, rsp_vout, rsp_z, rsp_err, rsp_tag, rsp_mismatch
//                               head of the response FIFO
//
// Build option
//   ALU_SEQ_GOLDEN_CHECK_EN  when defined, a reference model re-evaluates the
//   sampled operands and flags disagreement on rsp_mismatch; otherwise
//   rsp_mismatch is tied low.
//
// state | meaning
// IDLE  | waiting for a request; ready while the FIFO has space
// DRIVE | ALU inputs driven, settle counter running down to 0

module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_r,
    input  logic             alu_cout,
    input  logic             alu_vout,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_r,
    output logic             rsp_cout,
    output logic             rsp_vout,
    output logic             rsp_z,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_mismatch
);

    typedef enum logic {IDLE, DRIVE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
    // entry layout: {r, cout, vout, z, err, tag, mismatch}
    localparam int EW = 32 + 4 + TAG_W + 1;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_err_q;
    logic [TAG_W-1:0] pend_tag_q;
    logic             accept, push, pop;
    logic [1:0]       count_q;
    logic             rd_ptr_q, wr_ptr_q;
    logic [EW-1:0]    buf_q [2];
    logic [EW-1:0]    entry;
    logic             chk_mismatch;
    logic             req_legal;

    assign req_legal = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010) ||
                       (req_op == 3'b110) || (req_op == 3'b111);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = (count_q != 2'd2);
                if (req_valid && (count_q != 2'd2)) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_op     <= 3'd0;
            pend_err_q <= 1'b0;
            pend_tag_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_err_q <= ~req_legal;
                pend_tag_q <= req_tag;
                // illegal opcodes never reach the ALU; it keeps the last legal op
                if (req_legal) begin
                    alu_a  <= req_a;
                    alu_b  <= req_b;
                    alu_op <= req_op;
                end
            end
        end
    end

`ifdef ALU_SEQ_GOLDEN_CHECK_EN
    logic [32:0] g_add, g_sub;
    logic [31:0] g_r;
    logic        g_c, g_v, g_arith;

    assign g_add = {1'b0, alu_a} + {1'b0, alu_b};
    assign g_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;

    always_comb begin
        g_r     = alu_a & alu_b;
        g_c     = 1'b0;
        g_v     = 1'b0;
        g_arith = 1'b0;
        case (alu_op)
            3'b001: g_r = alu_a | alu_b;
            3'b010: begin
                g_r     = g_add[31:0];
                g_c     = g_add[32];
                g_v     = (alu_a[31] == alu_b[31]) && (g_add[31] != alu_a[31]);
                g_arith = 1'b1;
            end
            3'b110: begin
                g_r     = g_sub[31:0];
                g_c     = g_sub[32];
                g_v     = (alu_a[31] != alu_b[31]) && (g_sub[31] != alu_a[31]);
                g_arith = 1'b1;
            end
            3'b111: g_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: ;
        endcase
    end

    // flags are only meaningful for ADD/SUB; logic ops and SLT check r and z
    assign chk_mismatch = (alu_r != g_r) || (alu_z != (g_r == 32'd0)) ||
                          (g_arith && ((alu_cout != g_c) || (alu_vout != g_v)));
`else
    assign chk_mismatch = 1'b0;
`endif

    assign entry = pend_err_q ? {32'd0, 3'b000, 1'b1, pend_tag_q, 1'b0}
                              : {alu_r, alu_cout, alu_vout, alu_z, 1'b0, pend_tag_q, chk_mismatch};

    assign rsp_valid = (count_q != 2'd0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign {rsp_r, rsp_cout, rsp_vout, rsp_z, rsp_err, rsp_tag, rsp_mismatch} = buf_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int SETTLE   = 1;
    localparam int S_SETTLE = 5;
`ifdef ALU_SEQ_GOLDEN_CHECK_EN
    localparam bit GOLD = 1'b1;
`else
    localparam bit GOLD = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } alu_res_t;

    typedef struct {
        logic [31:0] r;
        logic        c, v, z, err, mm;
        logic [3:0]  tag;
    } rsp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [3:0]  tag;
        logic [31:0] r;
        logic        c, v, z, err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_r, rsp_r;
    logic [2:0]  req_op, alu_op;
    logic [3:0]  req_tag, rsp_tag;
    logic        alu_cout, alu_vout, alu_z;
    logic        rsp_cout, rsp_vout, rsp_z, rsp_err, rsp_mismatch;
    logic        fault_en;

    logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [31:0] s_alu_a, s_alu_b, s_alu_r, s_rsp_r;
    logic [2:0]  s_alu_op;
    logic [3:0]  s_rsp_tag;
    logic        s_alu_cout, s_alu_vout, s_alu_z;
    logic        s_rsp_cout, s_rsp_vout, s_rsp_z, s_rsp_err, s_rsp_mismatch;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic bit is_legal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
    endfunction

    // Behavioural ALU: plain 64-bit arithmetic, garbage for illegal opcodes.
    function automatic alu_res_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        alu_res_t       t;
        longint         sa, sb, ss;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        t  = '0;
        case (op)
            3'b000: t.r = a & b;
            3'b001: t.r = a | b;
            3'b010: begin
                t.r = 32'(ua + ub);
                t.c = (ua + ub) > 64'hFFFF_FFFF;
                ss  = sa + sb;
                t.v = (ss > SMAX) || (ss < SMIN);
            end
            3'b110: begin
                t.r = 32'(ua - ub);
                t.c = (ua >= ub);
                ss  = sa - sb;
                t.v = (ss > SMAX) || (ss < SMIN);
            end
            3'b111: t.r = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                t.r = a ^ b;
                t.c = 1'b1;
                t.v = 1'b1;
            end
        endcase
        t.z = (t.r == 32'd0);
        return t;
    endfunction

    function automatic rsp_t expect_rsp(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic [3:0] tag);
        rsp_t     e;
        alu_res_t t;
        t = alu_ref(a, b, op);
        if (is_legal(op)) begin
            e.r = t.r; e.c = t.c; e.v = t.v; e.z = t.z; e.err = 1'b0;
        end else begin
            e.r = 32'd0; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.err = 1'b1;
        end
        e.mm  = 1'b0;
        e.tag = tag;
        return e;
    endfunction

    alu_res_t alu_t, s_alu_t;
    always_comb begin
        alu_t = alu_ref(alu_a, alu_b, alu_op);
        if (fault_en && alu_op == 3'b000) alu_t.r[0] = ~alu_t.r[0];
    end
    assign {alu_r, alu_cout, alu_vout, alu_z} = alu_t;
    assign s_alu_t = alu_ref(s_alu_a, s_alu_b, s_alu_op);
    assign {s_alu_r, s_alu_cout, s_alu_vout, s_alu_z} = s_alu_t;

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_cout(alu_cout), .alu_vout(alu_vout), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_cout(rsp_cout), .rsp_vout(rsp_vout), .rsp_z(rsp_z),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag), .rsp_mismatch(rsp_mismatch)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(S_SETTLE), .TAG_W(4)) dut_slow (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(32'd3), .req_b(32'd4), .req_op(3'b010), .req_tag(4'd6),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
        .alu_r(s_alu_r), .alu_cout(s_alu_cout), .alu_vout(s_alu_vout), .alu_z(s_alu_z),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_r(s_rsp_r), .rsp_cout(s_rsp_cout), .rsp_vout(s_rsp_vout), .rsp_z(s_rsp_z),
        .rsp_err(s_rsp_err), .rsp_tag(s_rsp_tag), .rsp_mismatch(s_rsp_mismatch)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rsp(input string name, input rsp_t e);
        chk(name, {rsp_r, rsp_cout, rsp_vout, rsp_z, rsp_err, rsp_mismatch, rsp_tag},
                  {e.r, e.c, e.v, e.z, e.err, e.mm, e.tag});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        int n;
        req_op = op; req_a = a; req_b = b; req_tag = tag;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) chk("send_timeout", 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag, input rsp_t e);
        logic [66:0] prev_alu;
        int n;
        rsp_ready = 1'b1;
        prev_alu  = {alu_a, alu_b, alu_op};
        send(op, a, b, tag);
        if (is_legal(op)) chk({name, "_alu"}, {alu_a, alu_b, alu_op}, {a, b, op});
        else              chk({name, "_alu_hold"}, {alu_a, alu_b, alu_op}, prev_alu);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, SETTLE);
        chk_rsp({name, "_rsp"}, e);
        chk({name, "_ready_back"}, req_ready, 1'b1);
        tick();
        chk({name, "_drained"}, rsp_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[13];
        rsp_t  e;
        rsp_t  q[$];
        logic [3:0] got[3];
        int    ngot, n, sent;
        bit    stale, acc, pp;
        logic [2:0]  op_s;
        logic [31:0] a_s, b_s;
        logic [31:0] corner[4];

        vecs[0]  = '{3'b010, 32'h6F0F0F5A, 32'h6F0F0F5A, 4'd1, 32'hDE1E1EB4, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b110, 32'h6F0F0F5A, 32'h6F0F0F5A, 4'd2, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'b111, 32'h6F0F0F5A, 32'h6F0F0F5A, 4'd3, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'b010, 32'hEF0B4D5A, 32'h6F4F0B5A, 4'd4, 32'h5E5A58B4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 32'hEF0B4D5A, 32'h6F4F0B5A, 4'd5, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 32'hF0F0FFFF, 32'h0FF0F00F, 4'd6, 32'h00F0F00F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 32'h12340000, 32'h00005678, 4'd7, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 32'h00000001, 32'h00000002, 4'd8, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 32'h80000000, 32'h00000001, 4'd9, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 32'hDEADBEEF, 32'h12345678, 4'hA, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'b011, 32'h0000FFFF, 32'h0000FFFF, 4'hB, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 4'hC, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{3'b111, 32'h80000000, 32'h00000000, 4'hD, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        corner[0] = 32'h0; corner[1] = 32'hFFFFFFFF; corner[2] = 32'h80000000; corner[3] = 32'h7FFFFFFF;

        req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b0; fault_en = 1'b0;
        s_req_valid = 1'b0; s_rsp_ready = 1'b1;

        // reset state
        #22 rst_n = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_fields", {rsp_r, rsp_cout, rsp_vout, rsp_z, rsp_err, rsp_tag, rsp_mismatch}, 64'd0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 64'd0);
        tick();

        // latency with a longer settle window
        s_req_valid = 1'b1;
        tick();
        s_req_valid = 1'b0;
        n = 0;
        stale = 1'b0;
        while (!s_rsp_valid && n < 40) begin
            if (s_req_ready) stale = 1'b1;
            tick();
            n++;
        end
        chk("slow_latency", n, S_SETTLE);
        chk("slow_ready_low_in_drive", stale, 1'b0);
        chk("slow_rsp", {s_rsp_r, s_rsp_tag, s_rsp_err}, {32'd7, 4'd6, 1'b0});
        chk("slow_ready_back", s_req_ready, 1'b1);

        // directed vectors
        for (int i = 0; i < 13; i++) begin
            e = '{vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].err, 1'b0, vecs[i].tag};
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, e);
        end

        // golden check against a faulty AND result
        fault_en = 1'b1;
        e = '{32'h0F0F0001, 1'b0, 1'b0, 1'b0, 1'b0, GOLD, 4'hE};
        run_one("golden_and_fault", 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 4'hE, e);
        fault_en = 1'b0;

        // backpressure: two buffered, third waits
        rsp_ready = 1'b0;
        send(3'b010, 32'd1, 32'd1, 4'd1);
        send(3'b010, 32'd2, 32'd2, 4'd2);
        req_op = 3'b010; req_a = 32'd3; req_b = 32'd3; req_tag = 4'd3;
        req_valid = 1'b1;
        repeat (4) tick();
        chk("bp_full_ready_low", req_ready, 1'b0);
        chk("bp_head", {rsp_valid, rsp_tag, rsp_r}, {1'b1, 4'd1, 32'd2});
        rsp_ready = 1'b1;
        ngot = 0;
        n = 0;
        while (ngot < 3 && n < 30) begin
            acc = req_valid && req_ready;
            if (rsp_valid) begin
                got[ngot] = rsp_tag;
                ngot++;
            end
            tick();
            if (acc) req_valid = 1'b0;
            n++;
        end
        req_valid = 1'b0;
        chk("bp_count", ngot, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("bp_order%0d", i), got[i], 4'(i + 1));
        tick();

        // randomized traffic against the scoreboard
        sent = 0;
        n = 0;
        req_valid = 1'b0;
        while (!(sent == 200 && q.size() == 0 && !rsp_valid) && n < 8000) begin
            acc  = req_valid && req_ready;
            pp   = rsp_valid && rsp_ready;
            op_s = req_op; a_s = req_a; b_s = req_b;
            if (pp) begin
                if (q.size() == 0) chk("rand_unexpected_rsp", 64'd1, 64'd0);
                else chk_rsp("rand_rsp", q.pop_front());
            end
            if (acc) begin
                q.push_back(expect_rsp(req_a, req_b, req_op, req_tag));
                sent++;
            end
            tick();
            if (acc && is_legal(op_s)) chk("rand_alu", {alu_a, alu_b, alu_op}, {a_s, b_s, op_s});
            req_valid = (sent < 200) && ($urandom_range(0, 2) != 0);
            req_op    = 3'($urandom_range(0, 7));
            req_a     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
            req_b     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
            req_tag   = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        req_valid = 1'b0;
        chk("rand_complete", {sent, q.size()}, {32'd200, 32'd0});

        // reset during DRIVE with one entry buffered
        rsp_ready = 1'b0;
        send(3'b010, 32'd7, 32'd8, 4'd5);
        tick();
        chk("mid_one_buffered", rsp_valid, 1'b1);
        send(3'b001, 32'h55, 32'hAA, 4'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp", {rsp_valid, rsp_r, rsp_tag, rsp_err}, 64'd0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_op}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("mid_release_ready", req_ready, 1'b1);
        stale = 1'b0;
        repeat (6) begin
            tick();
            if (rsp_valid || !req_ready) stale = 1'b1;
        end
        chk("mid_no_stale", stale, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
